// File: rtl/grostl_round_ctrl.sv
// Iterative Grostl P/Q round sequencer: holds the 512-bit state and round index and loops the state
// through the external round datapath once per cycle for NUM_ROUNDS cycles.
module grostl_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_pq,
  input  logic [511:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_pq,
  output logic [511:0]         out_data,
  output logic                 busy,
  output logic [511:0]         rf_state,
  output logic                 rf_pq,
  output logic [RND_WIDTH-1:0] rf_rnd,
  input  logic [511:0]         rf_result
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << RND_WIDTH)) begin : g_param_check
    $error("grostl_round_ctrl: NUM_ROUNDS must lie in 1..2**RND_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Terminal compare against NUM_ROUNDS-1 so a full 2**RND_WIDTH count ends before the counter wraps.
  localparam logic [RND_WIDTH-1:0] LAST_RND = RND_WIDTH'(NUM_ROUNDS - 1);

  fsm_t                 r_fsm;
  fsm_t                 w_fsm_nxt;
  logic [511:0]         r_state;
  logic                 r_pq;
  logic [RND_WIDTH-1:0] r_rnd;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last;

  assign w_in_ready = !reset && ((r_fsm == IDLE) || ((r_fsm == DONE) && out_ready));
  assign w_accept   = in_valid && w_in_ready;
  assign w_last     = (r_rnd == LAST_RND);

  always_comb begin
    w_fsm_nxt = r_fsm;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_accept) w_fsm_nxt = RUN;
      end
      RUN: begin
        busy = !reset;
        if (w_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = !reset;
        if (out_ready) w_fsm_nxt = in_valid ? RUN : IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_pq    <= 1'b0;
      r_rnd   <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == RUN) begin
        r_state <= rf_result;
        r_rnd   <= w_last ? '0 : r_rnd + RND_WIDTH'(1);
      end else if (w_accept) begin
        r_state <= in_data;
        r_pq    <= in_pq;
        r_rnd   <= '0;
      end
    end
  end

  assign in_ready = w_in_ready;
  assign out_data = r_state;
  assign out_pq   = r_pq;
  assign rf_state = r_state;
  assign rf_pq    = r_pq;
  assign rf_rnd   = (r_fsm == RUN) ? r_rnd : '0;

endmodule

// File: tb/tb_grostl_round_ctrl.sv
// Bench for grostl_round_ctrl: NUM_ROUNDS=10 and NUM_ROUNDS=16 instances with stubbed round functions.
module tb_grostl_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_pq, out_ready, sel, xor_mode;
  logic [511:0] in_data;

  logic         a_in_ready, a_out_valid, a_out_pq, a_busy, a_rf_pq;
  logic [511:0] a_out_data, a_rf_state, a_rf_result;
  logic [3:0]   a_rf_rnd;
  logic         b_in_ready, b_out_valid, b_out_pq, b_busy, b_rf_pq;
  logic [511:0] b_out_data, b_rf_state, b_rf_result;
  logic [3:0]   b_rf_rnd;
  logic         a_in_valid, b_in_valid;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_rf_result = xor_mode ? (a_rf_state ^ {a_rf_pq, 507'b0, a_rf_rnd}) : (a_rf_state + 512'd1);
  assign b_rf_result = b_rf_state + 512'd1;

  grostl_round_ctrl #(.NUM_ROUNDS(10), .RND_WIDTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pq(in_pq),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_pq(a_out_pq),
    .out_data(a_out_data), .busy(a_busy), .rf_state(a_rf_state), .rf_pq(a_rf_pq),
    .rf_rnd(a_rf_rnd), .rf_result(a_rf_result));

  grostl_round_ctrl #(.NUM_ROUNDS(16), .RND_WIDTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pq(in_pq),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_pq(b_out_pq),
    .out_data(b_out_data), .busy(b_busy), .rf_state(b_rf_state), .rf_pq(b_rf_pq),
    .rf_rnd(b_rf_rnd), .rf_result(b_rf_result));

  logic         m_in_ready, m_out_valid, m_out_pq, m_busy, m_rf_pq;
  logic [511:0] m_out_data, m_rf_state;
  logic [3:0]   m_rf_rnd;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_pq    = sel ? b_out_pq    : a_out_pq;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_rf_pq     = sel ? b_rf_pq     : a_rf_pq;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_rf_state  = sel ? b_rf_state  : a_rf_state;
  assign m_rf_rnd    = sel ? b_rf_rnd    : a_rf_rnd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: the permutation result follows directly from the stub's algebra over nr rounds.
  function automatic logic [511:0] ref_perm(input logic [511:0] d, input logic pq, input logic xm, input int nr);
    logic [511:0] r;
    int x;
    if (!xm) return d + 512'(nr);
    x = 0;
    for (int i = 0; i < nr; i++) x = x ^ i;
    r = d ^ 512'(x);
    if (pq && (nr % 2 == 1)) r[511] = ~r[511];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [511:0] d, input logic pq, input logic [511:0] exp_d,
                         input logic exp_pq, input string nm);
    int k, nbusy, nr;
    bit seq_bad, pq_bad;
    nr = sel ? 16 : 10;
    k = 0;
    while (!m_in_ready && k < 50) begin step(); k++; end
    in_data = d; in_pq = pq; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_pq = ~pq; in_data = ~d;
    k = 0; nbusy = 0; seq_bad = 0; pq_bad = 0;
    while (!m_out_valid && k < 100) begin
      if (m_busy) begin
        if (m_rf_rnd !== 4'(nbusy)) seq_bad = 1;
        if (m_rf_pq !== pq) pq_bad = 1;
        nbusy++;
      end
      step();
      k++;
    end
    chk({nm, " accept_to_out_valid_edges"}, 512'(k), 512'(nr));
    chk({nm, " busy_cycles"}, 512'(nbusy), 512'(nr));
    chk({nm, " rf_rnd_sequence_bad"}, 512'(seq_bad), 512'd0);
    chk({nm, " rf_pq_not_held"}, 512'(pq_bad), 512'd0);
    chk({nm, " out_data"}, m_out_data, exp_d);
    chk({nm, " out_pq"}, 512'(m_out_pq), 512'(exp_pq));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, " out_valid_after_consume"}, 512'(m_out_valid), 512'd0);
  endtask

  typedef struct {
    logic [511:0] data;
    logic         pq;
    logic         xm;
    logic [511:0] exp_data;
    logic         exp_pq;
  } vec_t;

  vec_t vecs[8];
  logic [511:0] base[3];

  initial begin
    int k, nres, last_t, idx;
    logic acc;
    logic [511:0] d;

    vecs[0] = '{512'd0, 1'b0, 1'b0, 512'hA, 1'b0};
    vecs[1] = '{512'd0, 1'b1, 1'b1, 512'h1, 1'b1};
    vecs[2] = '{{512{1'b1}}, 1'b0, 1'b0, 512'h9, 1'b0};
    vecs[3] = '{512'h5, 1'b0, 1'b1, 512'h4, 1'b0};
    for (int i = 4; i < 8; i++) begin
      vecs[i].data = rand512();
      vecs[i].pq   = 1'($urandom_range(0, 1));
      vecs[i].xm   = 1'($urandom_range(0, 1));
      vecs[i].exp_data = ref_perm(vecs[i].data, vecs[i].pq, vecs[i].xm, 10);
      vecs[i].exp_pq   = vecs[i].pq;
    end

    reset = 1'b1; in_valid = 1'b0; in_pq = 1'b0; in_data = '0; out_ready = 1'b0;
    sel = 1'b0; xor_mode = 1'b0;
    step(); step();
    chk("reset in_ready", 512'(a_in_ready), 512'd0);
    chk("reset out_valid", 512'(a_out_valid), 512'd0);
    chk("reset busy", 512'(a_busy), 512'd0);
    chk("reset rf_state", a_rf_state, 512'd0);
    reset = 1'b0;
    #1;
    chk("idle in_ready", 512'(a_in_ready), 512'd1);
    chk("idle rf_rnd", 512'(a_rf_rnd), 512'd0);

    for (int i = 0; i < 8; i++) begin
      xor_mode = vecs[i].xm;
      run_job(vecs[i].data, vecs[i].pq, vecs[i].exp_data, vecs[i].exp_pq, $sformatf("vec%0d", i));
    end

    // Stall in DONE with a pending request, then consume and accept on the same edge.
    xor_mode = 1'b0;
    in_data = 512'd7; in_pq = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!a_out_valid && k < 100) begin step(); k++; end
    in_valid = 1'b1; in_data = 512'd100;
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", 512'(a_in_ready), 512'd0);
      chk("stall out_valid", 512'(a_out_valid), 512'd1);
      chk("stall out_data", a_out_data, 512'd17);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 512'(a_in_ready), 512'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("chained busy", 512'(a_busy), 512'd1);
    chk("chained out_valid", 512'(a_out_valid), 512'd0);
    chk("chained rf_state", a_rf_state, 512'd100);
    k = 0;
    while (!a_out_valid && k < 100) begin step(); k++; end
    chk("chained out_data", a_out_data, 512'd110);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Back-to-back: three jobs with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) base[i] = rand512();
    idx = 0; nres = 0; last_t = 0;
    in_data = base[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 60 && nres < 3; t++) begin
      if (a_out_valid) begin
        chk($sformatf("b2b result%0d", nres), a_out_data, base[nres] + 512'd10);
        if (nres > 0) chk($sformatf("b2b spacing%0d", nres), 512'(t - last_t), 512'd11);
        last_t = t;
        nres++;
      end
      acc = a_in_ready && in_valid;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) in_data = base[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b result_count", 512'(nres), 512'd3);
    step();

    // Reset asserted at round 4 aborts the job.
    in_data = 512'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (a_rf_rnd != 4'd4 && k < 20) begin step(); k++; end
    chk("abort reached round4", 512'(a_rf_rnd), 512'd4);
    reset = 1'b1;
    step();
    chk("abort out_valid", 512'(a_out_valid), 512'd0);
    chk("abort busy", 512'(a_busy), 512'd0);
    chk("abort rf_rnd", 512'(a_rf_rnd), 512'd0);
    chk("abort rf_state", a_rf_state, 512'd0);
    chk("abort in_ready", 512'(a_in_ready), 512'd0);
    reset = 1'b0;
    #1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid) k++;
      step();
    end
    chk("abort no_stray_out_valid", 512'(k), 512'd0);
    d = rand512();
    run_job(d, 1'b1, ref_perm(d, 1'b1, 1'b0, 10), 1'b1, "post_abort");

    // Full-width round count: 16 rounds on a 4-bit index.
    sel = 1'b1;
    #1;
    d = rand512();
    run_job(d, 1'b0, ref_perm(d, 1'b0, 1'b0, 16), 1'b0, "nr16");
    d = rand512();
    run_job(d, 1'b1, ref_perm(d, 1'b1, 1'b0, 16), 1'b1, "nr16b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
